// File: rtl/alu_op_decoder_pipe.sv
// alu_op_decoder_pipe: decodes ALUOp/Funct3/Funct7 into the ALU operation code behind a 2-entry skid buffer.
// Define ALU_DEC_ILLEGAL_EN to flag unsupported encodings on the illegal output.
module alu_op_decoder_pipe #(
    parameter int OPCODE_LENGTH = 4,
    parameter int ALUOP_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ALUOP_WIDTH-1:0]   ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     is_rtype,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);
    typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;
    state_t state, state_nxt;
    logic [3:0] code;
    logic [OPCODE_LENGTH-1:0] dec_op, skid_op;
    logic accept, pop, load_head, load_skid, head_from_skid;

    always_comb begin
        code = 4'b1111;
        case (ALUOp)
            2'b00: code = 4'b0010;
            2'b11: code = 4'b1101;
            2'b01: code = (Funct3 == 3'b000) ? 4'b1000 :
                          (Funct3 == 3'b001) ? 4'b1001 :
                          (Funct3 == 3'b100) ? 4'b1011 :
                          (Funct3 == 3'b101) ? 4'b1010 : 4'b1111;
            default: code = (Funct3 == 3'b000) ? ((is_rtype & Funct7[5]) ? 4'b0110 : 4'b0010) :
                            (Funct3 == 3'b111) ? 4'b0000 :
                            (Funct3 == 3'b110) ? 4'b0001 :
                            (Funct3 == 3'b100) ? 4'b0011 :
                            (Funct3 == 3'b001) ? 4'b0100 :
                            (Funct3 == 3'b101) ? (Funct7[5] ? 4'b0111 : 4'b0101) :
                            (Funct3 == 3'b010) ? 4'b1100 : 4'b1111;
        endcase
    end

    assign dec_op    = OPCODE_LENGTH'(code);
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        if (flush)
            state_nxt = EMPTY;
        else
            case (state)
                EMPTY: begin
                    load_head = accept;
                    state_nxt = accept ? HALF : EMPTY;
                end
                HALF: begin
                    load_head = accept & pop;
                    load_skid = accept & ~pop;
                    state_nxt = (accept & ~pop) ? FULL : (pop & ~accept) ? EMPTY : HALF;
                end
                FULL: begin
                    head_from_skid = pop;
                    state_nxt      = pop ? HALF : FULL;
                end
                default: state_nxt = EMPTY;
            endcase
    end

    // in_ready is registered from the next state so EX backpressure never reaches ID combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            Operation <= '0;
            skid_op   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt != FULL;
            if (load_head)
                Operation <= dec_op;
            else if (head_from_skid)
                Operation <= skid_op;
            if (load_skid)
                skid_op <= dec_op;
        end
    end

`ifdef ALU_DEC_ILLEGAL_EN
    logic dec_ill, head_ill, skid_ill;
    assign dec_ill = (code == 4'b1111) |
                     ((ALUOp == 2'b10) & ((is_rtype & (Funct7 != 7'h00) & (Funct7 != 7'h20)) |
                                          (Funct7[5] & (Funct3 != 3'b000) & (Funct3 != 3'b101))));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ill <= 1'b0;
            skid_ill <= 1'b0;
        end else begin
            if (load_head)
                head_ill <= dec_ill;
            else if (head_from_skid)
                head_ill <= skid_ill;
            if (load_skid)
                skid_ill <= dec_ill;
        end
    end
    assign illegal = head_ill;
`else
    assign illegal = 1'b0;
`endif
endmodule
